// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the UDP stream arbiter: FSM states, header constants,
// the registered transmit beat and counter/ID width helpers.
package adc_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    STREAM,
    DRAIN,
    GAP
  } arb_state_t;

  localparam logic [3:0]  HDR_MAGIC    = 4'hA;
  localparam int unsigned HDR_BYTES    = 2;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } tx_beat_t;

  // Bits needed to name one of n channels (at least 1).
  function automatic int unsigned ch_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count from 0 up to max_val inclusive (at least 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/udp_stream_arbiter_if.sv
// Channel FIFO read ports plus the UDP transmit byte stream shared by the arbiter.
interface udp_stream_arbiter_if #(
  parameter int unsigned N_CH = 4
) ();

  logic [N_CH-1:0]   ch_full;
  logic [N_CH-1:0]   ch_empty;
  logic [N_CH*8-1:0] ch_dout;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH-1:0]   ch_rd_en;
  logic              udp_tx_busy;
  logic              udp_tx_valid;
  logic [7:0]        udp_tx_data;

  modport master (
    input  ch_full, ch_empty, ch_dout, ch_valid, udp_tx_busy,
    output ch_rd_en, udp_tx_valid, udp_tx_data
  );

  modport slave (
    output ch_full, ch_empty, ch_dout, ch_valid, udp_tx_busy,
    input  ch_rd_en, udp_tx_valid, udp_tx_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter
  import adc_stream_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned IDW  = ch_id_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [N_CH-1:0] win,
  output logic            any
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan from ptr upward; the first hit wins and masks all later ones.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = IDW'((32'(ptr) + k) % N_CH);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/udp_stream_arbiter.sv
// Round-robin scheduler sharing one UDP transmit path between N_CH channel FIFOs.
// Define STREAM_HDR_EN to prefix each payload with a 2-byte {magic|ch_id, pkt_count} header.
module udp_stream_arbiter
  import adc_stream_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PKT_BYTES  = 1024,
  parameter int unsigned IFG_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  udp_stream_arbiter_if.master bus,
  output logic [N_CH-1:0]     grant,
  output logic                busy,
  output logic [15:0]         pkt_count,
  output logic                err_underrun
);

  localparam int unsigned IDW     = ch_id_w(N_CH);
  localparam int unsigned CNT_W   = cnt_w(PKT_BYTES);
  localparam int unsigned TMR_MAX = (IFG_CYCLES > DRAIN_CYCLES) ? IFG_CYCLES : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  arb_state_t       state, state_nxt;
  logic [N_CH-1:0]  grant_nxt;
  logic [IDW-1:0]   gid, gid_nxt;
  logic [IDW-1:0]   rr_ptr, rr_nxt;
  logic [CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [15:0]      pkt_nxt;
  logic             err_nxt;
  tx_beat_t         tx_nxt;
  logic             rd_go;

  logic [N_CH-1:0]  pick_win;
  logic             pick_any;
  logic [IDW-1:0]   pick_id;
  logic             sel_valid;
  logic             sel_empty;
  logic [7:0]       sel_data;

  rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req (bus.ch_full),
    .ptr (rr_ptr),
    .win (pick_win),
    .any (pick_any)
  );

  // One-hot winner to channel index.
  always_comb begin
    pick_id = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pick_win[i]) pick_id = IDW'(i);
    end
  end

  // Granted channel's FIFO signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gid == IDW'(i)) begin
        sel_valid = bus.ch_valid[i];
        sel_empty = bus.ch_empty[i];
        sel_data  = bus.ch_dout[8*i +: 8];
      end
    end
  end

  assign bus.ch_rd_en = rd_go ? grant : '0;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    gid_nxt    = gid;
    rr_nxt     = rr_ptr;
    rd_cnt_nxt = rd_cnt;
    tmr_nxt    = tmr;
    pkt_nxt    = pkt_count;
    err_nxt    = err_underrun;
    tx_nxt     = '0;
    rd_go      = 1'b0;

    case (state)
      IDLE: begin
        if (enable && !bus.udp_tx_busy && pick_any) begin
          grant_nxt  = pick_win;
          gid_nxt    = pick_id;
          rr_nxt     = (pick_id == IDW'(N_CH - 1)) ? '0 : pick_id + 1'b1;
          rd_cnt_nxt = '0;
          tmr_nxt    = '0;
`ifdef STREAM_HDR_EN
          state_nxt  = HDR;
`else
          state_nxt  = STREAM;
`endif
        end
      end

      // First read is issued on the last header byte so payload follows with no bubble.
      HDR: begin
        if (tmr != TMR_W'(HDR_BYTES - 1)) begin
          tx_nxt  = '{valid: 1'b1, data: {HDR_MAGIC, 4'(gid)}};
          tmr_nxt = tmr + 1'b1;
        end else begin
          tx_nxt    = '{valid: 1'b1, data: pkt_count[7:0]};
          tmr_nxt   = '0;
          state_nxt = STREAM;
          if (!sel_empty && rd_cnt < CNT_W'(PKT_BYTES)) begin
            rd_go      = 1'b1;
            rd_cnt_nxt = rd_cnt + 1'b1;
          end
        end
      end

      STREAM: begin
        tx_nxt  = '{valid: sel_valid, data: sel_data};
        tmr_nxt = '0;
        if (rd_cnt >= CNT_W'(PKT_BYTES)) begin
          state_nxt = DRAIN;
        end else if (sel_empty) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          rd_go      = 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
          if (rd_cnt == CNT_W'(PKT_BYTES - 1)) state_nxt = DRAIN;
        end
      end

      // Let the FIFO latency and the output register flush before counting the packet.
      DRAIN: begin
        tx_nxt = '{valid: sel_valid, data: sel_data};
        if (tmr == TMR_W'(DRAIN_CYCLES - 1)) begin
          pkt_nxt = pkt_count + 16'd1;
          tmr_nxt = '0;
          if (IFG_CYCLES == 0) begin
            grant_nxt = '0;
            state_nxt = IDLE;
          end else begin
            state_nxt = GAP;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      GAP: begin
        if (tmr == TMR_W'(IFG_CYCLES - 1)) begin
          grant_nxt = '0;
          tmr_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end

      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= '0;
      gid              <= '0;
      rr_ptr           <= '0;
      rd_cnt           <= '0;
      tmr              <= '0;
      pkt_count        <= '0;
      err_underrun     <= 1'b0;
      busy             <= 1'b0;
      bus.udp_tx_valid <= 1'b0;
      bus.udp_tx_data  <= '0;
    end else begin
      state            <= state_nxt;
      grant            <= grant_nxt;
      gid              <= gid_nxt;
      rr_ptr           <= rr_nxt;
      rd_cnt           <= rd_cnt_nxt;
      tmr              <= tmr_nxt;
      pkt_count        <= pkt_nxt;
      err_underrun     <= err_nxt;
      busy             <= (state_nxt != IDLE);
      bus.udp_tx_valid <= tx_nxt.valid;
      bus.udp_tx_data  <= tx_nxt.data;
    end
  end

endmodule
